// File: rtl/mac_rx_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_rx_parser: GMII rx parser - preamble/SFD strip, DA filter, header     |
// | decode, FCS-stripped payload stream. Optional 802.1Q strip: VLAN_TAG_EN.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mac_rx_parser #(
  parameter logic [47:0] MAC_ADDR     = 48'h0,
  parameter int          PROMISC      = 0,
  parameter int          ACCEPT_MCAST = 0,
  parameter int          MAX_PAYLOAD  = 1500,
  parameter int          MIN_FRAME    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [47:0] da,
  output logic [47:0] sa,
  output logic [15:0] ether_type,
  output logic [15:0] vlan_tci,
  output logic        hdr_valid,
  output logic        is_ip,
  output logic        is_arp,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        m_err,
  output logic        frame_good,
  output logic        frame_bad
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_DEST     = 3'd2,
    S_SOURCE   = 3'd3,
    S_TYPE     = 3'd4,
    S_VLAN     = 3'd5,
    S_PAYLOAD  = 3'd6,
    S_DROP     = 3'd7
  } state_t;

  localparam logic [15:0] PL_LIMIT    = 16'(MAX_PAYLOAD + 4);
  localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  state_t          r_state, w_next;
  logic [2:0]      r_idx;
  logic [31:0]     r_crc;
  logic [15:0]     r_byte_cnt;
  logic [15:0]     r_pl_cnt;
  logic            r_err;
  logic            r_trunc;
  logic [2:0]      r_held;
  logic [4:0][7:0] r_dl;

  logic [47:0] w_da_full;
  logic [15:0] w_type;
  logic        w_type_ip, w_type_arp, w_type_vlan, w_accept;
  logic        w_in_frame, w_eof, w_bad, w_push;

  // Reflected CRC-32 (poly 0x04C11DB7), LSB of each byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  assign w_da_full  = {da[39:0], rxd};
  assign w_type     = {ether_type[7:0], rxd};
  assign w_type_ip  = (w_type <= 16'd1500) || (w_type == 16'h0800);
  assign w_type_arp = (w_type == 16'h0806);
`ifdef VLAN_TAG_EN
  assign w_type_vlan = (w_type == 16'h8100);
`else
  assign w_type_vlan = 1'b0;
  assign vlan_tci    = 16'h0;
`endif
  assign w_accept = (w_da_full == MAC_ADDR) || (&w_da_full) || (PROMISC != 0) ||
                    ((ACCEPT_MCAST != 0) && w_da_full[40]);

  assign w_in_frame = rx_dv && (r_state inside {S_DEST, S_SOURCE, S_TYPE, S_VLAN, S_PAYLOAD});
  assign w_push     = (r_state == S_PAYLOAD) && rx_dv && (r_pl_cnt != PL_LIMIT);
  assign w_eof      = ((r_state == S_PAYLOAD) && !rx_dv) || ((r_state == S_DROP) && r_trunc);
  assign w_bad      = r_trunc || r_err || (r_held != 3'd5) ||
                      (r_crc != CRC_RESIDUE) || (r_byte_cnt < MIN_LEN);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (rx_dv) w_next = (rxd == 8'h55) ? S_PREAMBLE : S_DROP;
      S_PREAMBLE: begin
        if (!rx_dv)              w_next = S_IDLE;
        else if (rxd == 8'hD5)   w_next = S_DEST;
        else if (rxd != 8'h55)   w_next = S_DROP;
      end
      S_DEST: begin
        if (!rx_dv)              w_next = S_IDLE;
        else if (r_idx == 3'd5)  w_next = w_accept ? S_SOURCE : S_DROP;
      end
      S_SOURCE: begin
        if (!rx_dv)              w_next = S_IDLE;
        else if (r_idx == 3'd5)  w_next = S_TYPE;
      end
      S_TYPE: begin
        if (!rx_dv)              w_next = S_IDLE;
        else if (r_idx == 3'd1)
          w_next = w_type_vlan ? S_VLAN : ((w_type_ip || w_type_arp) ? S_PAYLOAD : S_DROP);
      end
      S_VLAN: begin
        if (!rx_dv)              w_next = S_IDLE;
        else if (r_idx == 3'd3)  w_next = (w_type_ip || w_type_arp) ? S_PAYLOAD : S_DROP;
      end
      S_PAYLOAD: begin
        if (!rx_dv)                     w_next = S_IDLE;
        else if (r_pl_cnt == PL_LIMIT)  w_next = S_DROP;
      end
      S_DROP:     if (!rx_dv) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_crc      <= '0;
      r_byte_cnt <= '0;
      r_pl_cnt   <= '0;
      r_err      <= 1'b0;
      r_trunc    <= 1'b0;
      r_held     <= '0;
      r_dl       <= '0;
      da         <= '0;
      sa         <= '0;
      ether_type <= '0;
`ifdef VLAN_TAG_EN
      vlan_tci   <= '0;
`endif
      hdr_valid  <= 1'b0;
      is_ip      <= 1'b0;
      is_arp     <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_err      <= 1'b0;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
    end else begin
      hdr_valid  <= 1'b0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_err      <= 1'b0;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
      r_idx      <= (w_next != r_state) ? 3'd0 : r_idx + 3'd1;

      if (r_state == S_PREAMBLE) begin
        r_byte_cnt <= '0;
        r_pl_cnt   <= '0;
        r_err      <= 1'b0;
        r_trunc    <= 1'b0;
        r_held     <= '0;
`ifdef VLAN_TAG_EN
        vlan_tci   <= '0;
`endif
      end

      if (w_in_frame) begin
        r_crc <= crc32_byte(((r_state == S_DEST) && (r_idx == 3'd0)) ? 32'hFFFFFFFF : r_crc, rxd);
        if (r_byte_cnt != 16'hFFFF) r_byte_cnt <= r_byte_cnt + 16'd1;
        if (rx_er) r_err <= 1'b1;
      end

      case (r_state)
        S_DEST:   if (rx_dv) da <= w_da_full; else frame_bad <= 1'b1;
        S_SOURCE: if (rx_dv) sa <= {sa[39:0], rxd}; else frame_bad <= 1'b1;
        S_TYPE: begin
          if (rx_dv) begin
            ether_type <= w_type;
            if (r_idx == 3'd1) begin
              hdr_valid <= w_type_ip || w_type_arp;
              is_ip     <= w_type_ip;
              is_arp    <= w_type_arp;
            end
          end else begin
            frame_bad <= 1'b1;
          end
        end
        S_VLAN: begin
          if (rx_dv) begin
            // First two tag bytes are the TCI, the last two the inner type.
            if (r_idx < 3'd2) begin
`ifdef VLAN_TAG_EN
              vlan_tci <= {vlan_tci[7:0], rxd};
`endif
            end else begin
              ether_type <= w_type;
            end
            if (r_idx == 3'd3) begin
              hdr_valid <= w_type_ip || w_type_arp;
              is_ip     <= w_type_ip;
              is_arp    <= w_type_arp;
            end
          end else begin
            frame_bad <= 1'b1;
          end
        end
        S_PAYLOAD: if (rx_dv && (r_pl_cnt == PL_LIMIT)) r_trunc <= 1'b1;
        default: ;
      endcase

      if (w_push) begin
        if (r_held == 3'd5) begin
          m_valid <= 1'b1;
          m_data  <= r_dl[4];
        end else begin
          r_held <= r_held + 3'd1;
        end
        r_dl     <= {r_dl[3:0], rxd};
        r_pl_cnt <= r_pl_cnt + 16'd1;
      end

      // The last four held bytes are the FCS, so only the fifth-oldest leaves.
      if (w_eof) begin
        if (r_held == 3'd5) begin
          m_valid <= 1'b1;
          m_data  <= r_dl[4];
          m_last  <= 1'b1;
          m_err   <= w_bad;
        end
        frame_good <= ~w_bad;
        frame_bad  <= w_bad;
        is_ip      <= 1'b0;
        is_arp     <= 1'b0;
        r_held     <= '0;
        r_trunc    <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_rx_parser.sv
`default_nettype none
// Randomized scoreboard bench for mac_rx_parser: whole-frame reference model
// queues expected header/beat/frame events, a negedge monitor consumes them.
module tb_mac_rx_parser;
  localparam logic [47:0] MY_MAC    = 48'h02_00_00_00_00_01;
  localparam int          TB_PROM   = 0;
  localparam int          TB_MCAST  = 0;
  localparam int          MAXP      = 1500;
  localparam int          MINF      = 64;
`ifdef VLAN_TAG_EN
  localparam bit          VLAN_ON   = 1'b1;
`else
  localparam bit          VLAN_ON   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rxd;
  logic        rx_dv, rx_er;
  logic [47:0] da, sa;
  logic [15:0] ether_type, vlan_tci;
  logic        hdr_valid, is_ip, is_arp;
  logic [7:0]  m_data;
  logic        m_valid, m_last, m_err, frame_good, frame_bad;

  always #5 clk = ~clk;

  mac_rx_parser #(
    .MAC_ADDR(MY_MAC), .PROMISC(TB_PROM), .ACCEPT_MCAST(TB_MCAST),
    .MAX_PAYLOAD(MAXP), .MIN_FRAME(MINF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
    .da(da), .sa(sa), .ether_type(ether_type), .vlan_tci(vlan_tci),
    .hdr_valid(hdr_valid), .is_ip(is_ip), .is_arp(is_arp),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_err(m_err),
    .frame_good(frame_good), .frame_bad(frame_bad)
  );

  typedef struct packed { logic [7:0] data; logic last; logic err; } beat_t;
  typedef struct packed {
    logic [47:0] da; logic [47:0] sa; logic [15:0] et; logic [15:0] tci; logic ip; logic arp;
  } hdr_t;

  beat_t beat_q[$];
  hdr_t  hdr_q[$];
  bit    frame_q[$];
  int    checks = 0;
  int    errors = 0;
  int    beats_seen = 0;
  int    events_seen = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void unexpected(input string nm, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h with nothing expected", nm, act);
  endfunction

  function automatic logic [31:0] fcs_of(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i])
      for (int k = 0; k < 8; k++)
        c = (c[0] ^ b[i][k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return ~c;
  endfunction

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid) begin
        beats_seen++;
        events_seen++;
        if (beat_q.size() == 0) unexpected("beat", {m_data, m_last, m_err});
        else chk("beat", {m_data, m_last, m_err}, beat_q.pop_front());
      end
      if (hdr_valid) begin
        hdr_t h;
        events_seen++;
        if (hdr_q.size() == 0) unexpected("hdr_valid", {ether_type, da[47:0]});
        else begin
          h = hdr_q.pop_front();
          chk("hdr_da", da, h.da);
          chk("hdr_sa", sa, h.sa);
          chk("hdr_type", ether_type, h.et);
          chk("hdr_tci", vlan_tci, h.tci);
          chk("hdr_ip_arp", {is_ip, is_arp}, {h.ip, h.arp});
        end
      end
      if (frame_good || frame_bad) begin
        events_seen++;
        if (frame_q.size() == 0) unexpected("frame_pulse", {frame_good, frame_bad});
        else begin
          bit g;
          g = frame_q.pop_front();
          chk("frame_status", {frame_good, frame_bad}, {g, ~g});
          chk("eof_ip_arp_clear", {is_ip, is_arp}, 2'b00);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit er);
    rxd = b; rx_dv = 1'b1; rx_er = er;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rxd = 8'h00; rx_dv = 1'b0; rx_er = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preamble(input int n55);
    for (int i = 0; i < n55; i++) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_da"}, da, 48'h0);
    chk({tag, "_sa"}, sa, 48'h0);
    chk({tag, "_misc"}, {ether_type, vlan_tci, m_data, hdr_valid, is_ip, is_arp,
                         m_valid, m_last, m_err, frame_good, frame_bad}, 64'h0);
  endtask

  // Builds a frame, queues what the parser must report for it, then sends it.
  task automatic run_frame(input logic [47:0] fda, input logic [15:0] et, input int plen,
                           input bit corrupt, input bit er, input bit vlan,
                           input logic [15:0] tci, input int pre);
    logic [7:0]  f[$];
    logic [47:0] fsa;
    logic [31:0] fcs;
    bit          acc, ip, arp, bad;
    int          hl, n, er_at;
    fsa = {16'h0A0B, 32'($urandom())};
    f = {};
    for (int i = 0; i < 6; i++) f.push_back(fda[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(fsa[47-8*i -: 8]);
    if (vlan) begin
      f.push_back(8'h81); f.push_back(8'h00); f.push_back(tci[15:8]); f.push_back(tci[7:0]);
    end
    f.push_back(et[15:8]); f.push_back(et[7:0]);
    hl = f.size();
    for (int i = 0; i < plen; i++) f.push_back(8'($urandom()));
    fcs = fcs_of(f);
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
    if (corrupt) begin
      int p;
      p = f.size() - 1 - int'($urandom_range(0, 3));
      f[p] = f[p] ^ (8'h01 << $urandom_range(0, 7));
    end
    er_at = er ? hl + int'($urandom_range(0, f.size() - 1 - hl)) : -1;

    acc = (fda == MY_MAC) || (&fda) || (TB_PROM != 0) || ((TB_MCAST != 0) && fda[40]);
    ip  = (et <= 16'd1500) || (et == 16'h0800);
    arp = (et == 16'h0806);
    if (vlan && !VLAN_ON) acc = 1'b0;
    if (acc && (ip || arp)) begin
      hdr_q.push_back('{da: fda, sa: fsa, et: et, tci: vlan ? tci : 16'h0, ip: ip, arp: arp});
      n = f.size() - hl;
      if (n > MAXP + 4) begin
        for (int i = 0; i < MAXP; i++)
          beat_q.push_back('{data: f[hl+i], last: (i == MAXP-1), err: (i == MAXP-1)});
        frame_q.push_back(1'b0);
      end else begin
        bad = corrupt || er || (f.size() < MINF) || (n < 5);
        for (int i = 0; i < n - 4; i++)
          beat_q.push_back('{data: f[hl+i], last: (i == n-5), err: (i == n-5) && bad});
        frame_q.push_back(!bad);
      end
    end

    preamble(pre);
    foreach (f[i]) send_byte(f[i], i == er_at);
    idle(1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int b0, e0;
    rst_n = 1'b0; rxd = 8'h00; rx_dv = 1'b0; rx_er = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);

    b0 = beats_seen;
    run_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 46, 1'b0, 1'b0, 1'b0, 16'h0, 7);
    idle(3);
    chk("arp64_beats", 64'(beats_seen - b0), 64'd46);

    run_frame(MY_MAC, 16'h0800, 46, 1'b1, 1'b0, 1'b0, 16'h0, 7);
    idle(3);

    e0 = events_seen;
    run_frame(48'h02_00_00_00_00_99, 16'h0800, 46, 1'b0, 1'b0, 1'b0, 16'h0, 7);
    idle(3);
    chk("filtered_events", 64'(events_seen - e0), 64'd0);

    b0 = beats_seen;
    run_frame(MY_MAC, 16'h0800, 1600, 1'b0, 1'b0, 1'b0, 16'h0, 7);
    idle(3);
    chk("oversize_beats", 64'(beats_seen - b0), 64'(MAXP));

    if (VLAN_ON) begin
      run_frame(MY_MAC, 16'h0800, 46, 1'b0, 1'b0, 1'b1, 16'h0064, 7);
      idle(3);
    end

    e0 = events_seen;
    preamble(7);
    for (int i = 0; i < 6; i++) send_byte(MY_MAC[47-8*i -: 8], 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom()), 1'b0);
    frame_q.push_back(1'b0);
    idle(3);
    chk("hdr_abort_events", 64'(events_seen - e0), 64'd1);

    preamble(7);
    for (int i = 0; i < 4; i++) send_byte(MY_MAC[47-8*i -: 8], 1'b0);
    rst_n = 1'b0; rx_dv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    run_frame(MY_MAC, 16'h0800, 50, 1'b0, 1'b0, 1'b0, 16'h0, 7);
    idle(3);

    e0 = events_seen;
    send_byte(8'h55, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'hAA, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(MY_MAC[47-8*i -: 8], 1'b0);
    for (int i = 0; i < 60; i++) send_byte(8'($urandom()), 1'b0);
    idle(3);
    chk("bad_preamble_events", 64'(events_seen - e0), 64'd0);

    for (int n = 0; n < 40; n++) begin
      logic [47:0] rda;
      logic [15:0] ret;
      bit          rvl;
      int          rpl;
      rvl = 1'b0;
      case ($urandom_range(0, 4))
        0, 1:    rda = MY_MAC;
        2:       rda = 48'hFFFF_FFFF_FFFF;
        3:       rda = {16'h0200, 32'($urandom())};
        default: rda = {24'h01005E, 24'($urandom())};
      endcase
      case ($urandom_range(0, 5))
        0, 1:    ret = 16'h0800;
        2:       ret = 16'h0806;
        3:       ret = 16'($urandom_range(0, 1500));
        4:       ret = 16'h86DD;
        default: begin ret = 16'h0800; rvl = 1'b1; end
      endcase
      rpl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(40, 90));
      run_frame(rda, ret, rpl, $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
                rvl, 16'($urandom()), int'($urandom_range(1, 7)));
      idle(int'($urandom_range(1, 4)));
    end

    for (int i = 0; i < 50 && (beat_q.size() + hdr_q.size() + frame_q.size()) != 0; i++)
      @(posedge clk);
    chk("drain_beats", 64'(beat_q.size()), 64'd0);
    chk("drain_hdrs", 64'(hdr_q.size()), 64'd0);
    chk("drain_frames", 64'(frame_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
